// File: rtl/gcd_pkg.sv
// Shared types for the gcd arbiter: FSM state encoding and default datapath width.
package gcd_pkg;

  localparam int GCD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/gcd_arbiter_if.sv
// Requester-side bus of the gcd arbiter: request levels, packed operands,
// accept pulses and the shared response channel.
interface gcd_arbiter_if
  import gcd_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = GCD_WIDTH
);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_opa;
  logic [NREQ*WIDTH-1:0] req_opb;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_error;

  // Client side drives requests and listens for ack/response.
  modport master (
    output req, req_opa, req_opb,
    input  ack, rsp_valid, rsp_result, rsp_error
  );

  // Arbiter side.
  modport slave (
    input  req, req_opa, req_opb,
    output ack, rsp_valid, rsp_result, rsp_error
  );

endinterface

// File: rtl/gcd_rr_pick.sv
// Combinational round-robin picker: first set request bit strictly after
// last_grant, wrapping modulo NREQ, so last_grant itself has lowest priority.
module gcd_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic                    any,
  output logic [$clog2(NREQ)-1:0] owner
);

  localparam int IW = $clog2(NREQ);

  // Walk offsets 1..NREQ from last_grant; the first hit wins.
  always_comb begin
    int idx;
    idx   = 0;
    any   = 1'b0;
    owner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!any && req[idx]) begin
        any   = 1'b1;
        owner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin scheduler sharing one gcd datapath among NREQ requesters.
// Sequences start/done with the unit, blanks stale done in the first WAIT
// cycle, aborts after TIMEOUT WAIT cycles, and bypasses zero operands.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = GCD_WIDTH,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             reset,
  gcd_arbiter_if.slave     bus,
  output logic             busy,
  output logic [WIDTH-1:0] gcd_opa,
  output logic [WIDTH-1:0] gcd_opb,
  output logic             gcd_start,
  input  logic [WIDTH-1:0] gcd_result,
  input  logic             gcd_done
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state_reg, state_next;
  logic [IW-1:0]     owner_reg, owner_next;
  logic [IW-1:0]     last_grant_reg, last_grant_next;
  logic [WIDTH-1:0]  opa_reg, opa_next;
  logic [WIDTH-1:0]  opb_reg, opb_next;
  logic [TW-1:0]     timer_reg, timer_next;
  logic [NREQ-1:0]   ack_reg, ack_next;
  logic              start_reg, start_next;
  logic [NREQ-1:0]   valid_reg, valid_next;
  logic [WIDTH-1:0]  result_reg, result_next;
  logic              error_reg, error_next;

  logic              pick_any;
  logic [IW-1:0]     pick_owner;
  logic [WIDTH-1:0]  sel_a, sel_b;

  gcd_rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (bus.req),
    .last_grant (last_grant_reg),
    .any        (pick_any),
    .owner      (pick_owner)
  );

  assign sel_a = bus.req_opa[pick_owner*WIDTH +: WIDTH];
  assign sel_b = bus.req_opb[pick_owner*WIDTH +: WIDTH];

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    opa_next        = opa_reg;
    opb_next        = opb_reg;
    timer_next      = timer_reg;
    ack_next        = '0;
    start_next      = 1'b0;
    valid_next      = '0;
    result_next     = result_reg;
    error_next      = error_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          owner_next = pick_owner;
          opa_next   = sel_a;
          opb_next   = sel_b;
          ack_next   = NREQ'(1) << pick_owner;
          if (sel_a == '0 || sel_b == '0) begin
            // gcd(a,0)=a, gcd(0,b)=b: answer without touching the unit.
            state_next  = RESP;
            valid_next  = NREQ'(1) << pick_owner;
            result_next = sel_a | sel_b;
            error_next  = 1'b0;
          end else begin
            state_next = LAUNCH;
            start_next = 1'b1;
          end
        end
      end
      LAUNCH: begin
        timer_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        timer_next = timer_reg + TW'(1);
        // A done seen with timer==0 may belong to a previous operation.
        if (gcd_done && timer_reg != '0) begin
          state_next  = RESP;
          valid_next  = NREQ'(1) << owner_reg;
          result_next = gcd_result;
          error_next  = 1'b0;
        end else if (timer_reg == TW'(TIMEOUT)) begin
          state_next  = RESP;
          valid_next  = NREQ'(1) << owner_reg;
          result_next = '0;
          error_next  = 1'b1;
        end
      end
      RESP: begin
        last_grant_next = owner_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_grant_reg <= IW'(NREQ - 1);
      opa_reg        <= '0;
      opb_reg        <= '0;
      timer_reg      <= '0;
      ack_reg        <= '0;
      start_reg      <= 1'b0;
      valid_reg      <= '0;
      result_reg     <= '0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      opa_reg        <= opa_next;
      opb_reg        <= opb_next;
      timer_reg      <= timer_next;
      ack_reg        <= ack_next;
      start_reg      <= start_next;
      valid_reg      <= valid_next;
      result_reg     <= result_next;
      error_reg      <= error_next;
    end
  end

  assign bus.ack        = ack_reg;
  assign bus.rsp_valid  = valid_reg;
  assign bus.rsp_result = result_reg;
  assign bus.rsp_error  = error_reg;
  assign gcd_opa        = opa_reg;
  assign gcd_opb        = opb_reg;
  assign gcd_start      = start_reg;
  assign busy           = (state_reg != IDLE);

endmodule
